// File: rtl/board_write_scheduler.sv
// board_write_scheduler
// Shares the single write port of the board tile RAM between N_REQ movers
// (index 0 is Pac-Man, then the ghosts and the pellet logic). Each requester
// posts an atomic move: restore the tile at old_addr, then draw the sprite at
// new_addr. A round-robin arbiter picks one move. A four-state FSM
// (IDLE/CLEAR/DRAW/DONE) issues the two writes back-to-back and then pulses
// ack to the winner. Every output is registered, so each output reflects the
// state the FSM was in one cycle earlier.
//
// Optional build macro: PAC_PRIORITY_EN. When it is defined, requester 0 wins
// whenever it requests, and the remaining requesters share the port round-robin.
module board_write_scheduler #(
    parameter int N_REQ        = 4,
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 4,
    parameter int BOARD_BLOCKS = 768,
    localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] old_addr,
    input  logic [N_REQ*DATA_W-1:0] old_data,
    input  logic [N_REQ*ADDR_W-1:0] new_addr,
    input  logic [N_REQ*DATA_W-1:0] new_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id,
    output logic                    wren,
    output logic [ADDR_W-1:0]       write_addr,
    output logic [DATA_W-1:0]       write_data,
    output logic                    err
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
    // One bit wider than an address, so that BOARD_BLOCKS == 2**ADDR_W still works.
    localparam logic [ADDR_W:0] LIMIT   = (ADDR_W + 1)'(BOARD_BLOCKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Returns the next index in the requester ring, wrapping to 0.
    function automatic logic [ID_W-1:0] ring_next(input logic [ID_W-1:0] idx);
        return (idx == LAST_ID) ? '0 : idx + ID_W'(1);
    endfunction

    // Returns the first set request after 'from', searching upward with wrap.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [ID_W-1:0]  from);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] pick;
        logic            found;
        idx   = from;
        pick  = from;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ring_next(idx);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Returns 1 when the block address lies on the visible board.
    function automatic logic in_board(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    // Unpacked views of the packed per-requester command fields.
    logic [ADDR_W-1:0] w_old_addr_a [N_REQ];
    logic [DATA_W-1:0] w_old_data_a [N_REQ];
    logic [ADDR_W-1:0] w_new_addr_a [N_REQ];
    logic [DATA_W-1:0] w_new_data_a [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_old_addr_a[gi] = old_addr[gi*ADDR_W +: ADDR_W];
        assign w_old_data_a[gi] = old_data[gi*DATA_W +: DATA_W];
        assign w_new_addr_a[gi] = new_addr[gi*ADDR_W +: ADDR_W];
        assign w_new_data_a[gi] = new_data[gi*DATA_W +: DATA_W];
    end

    // Control and registered-output state.
    state_t            r_state;
    logic [ID_W-1:0]   r_last;
    logic [ID_W-1:0]   r_gid;
    logic              r_wren;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [N_REQ-1:0]  r_ack;
    logic              r_err;
    logic              r_busy;

    // Latched command. These are data registers, so they have no reset.
    logic [ADDR_W-1:0] r_old_addr;
    logic [DATA_W-1:0] r_old_data;
    logic [ADDR_W-1:0] r_new_addr;
    logic [DATA_W-1:0] r_new_data;

    // Next-state values.
    state_t            w_state_nxt;
    logic [ID_W-1:0]   w_last_nxt;
    logic [ID_W-1:0]   w_gid_nxt;
    logic              w_wren_nxt;
    logic [ADDR_W-1:0] w_waddr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic [N_REQ-1:0]  w_ack_nxt;
    logic              w_err_nxt;
    logic              w_busy_nxt;
    logic              w_latch;
    logic [ID_W-1:0]   w_pick;
    logic              w_same;
    logic              w_old_ok;
    logic              w_new_ok;

`ifdef PAC_PRIORITY_EN
    localparam logic [N_REQ-1:0] GHOST_MASK = {{(N_REQ-1){1'b1}}, 1'b0};
    // Pac-Man first; otherwise rotate among the other requesters only.
    assign w_pick = req[0] ? '0 : rr_pick(req & GHOST_MASK, r_last);
`else
    assign w_pick = rr_pick(req, r_last);
`endif

    assign w_same   = (r_old_addr == r_new_addr);
    assign w_old_ok = in_board(r_old_addr);
    assign w_new_ok = in_board(r_new_addr);

    // Next-state and next-output decode. Every value gets a default first.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_gid_nxt   = r_gid;
        w_wren_nxt  = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_ack_nxt   = '0;
        w_err_nxt   = 1'b0;
        w_busy_nxt  = (r_state != S_IDLE);
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_latch     = 1'b1;
                    w_gid_nxt   = w_pick;
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // If the sprite does not move, skip the restore write; DRAW repaints the block.
                w_waddr_nxt = r_old_addr;
                w_wdata_nxt = r_old_data;
                w_wren_nxt  = w_old_ok && !w_same;
                w_err_nxt   = !w_old_ok;
                w_state_nxt = S_DRAW;
            end
            S_DRAW: begin
                w_waddr_nxt = r_new_addr;
                w_wdata_nxt = r_new_data;
                w_wren_nxt  = w_new_ok;
                w_err_nxt   = !w_new_ok;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_ack_nxt[r_gid] = 1'b1;
`ifdef PAC_PRIORITY_EN
                if (r_gid != '0) begin
                    w_last_nxt = r_gid;
                end
`else
                w_last_nxt = r_gid;
`endif
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and registered outputs, with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= LAST_ID;
            r_gid   <= '0;
            r_wren  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_gid   <= w_gid_nxt;
            r_wren  <= w_wren_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Capture the winner's command in IDLE; inputs are not looked at again until the next IDLE.
    always_ff @(posedge CLOCK_50) begin
        if (w_latch) begin
            r_old_addr <= w_old_addr_a[w_pick];
            r_old_data <= w_old_data_a[w_pick];
            r_new_addr <= w_new_addr_a[w_pick];
            r_new_data <= w_new_data_a[w_pick];
        end
    end

    assign ack        = r_ack;
    assign busy       = r_busy;
    assign grant_id   = r_gid;
    assign wren       = r_wren;
    assign write_addr = r_waddr;
    assign write_data = r_wdata;
    assign err        = r_err;

endmodule

// File: doc/board_write_scheduler.md
Name: board_write_scheduler

Overview:
- Shares the single write port of the board tile RAM between up to N_REQ movers: Pac-Man, ghosts and the pellet logic.
- Each requester submits an atomic "move" command: restore the old tile, then draw the sprite tile at the new block.
- A round-robin arbiter picks one command; a small FSM issues the two RAM writes back-to-back and acknowledges the winner.
- Sits between the per-actor behaviour blocks and the board RAM's wren/wraddress/data inputs, all in the CLOCK_50 domain.

Parameters:
- N_REQ, 4, number of requesters; index 0 is Pac-Man.
- ADDR_W, 10, board block address width.
- DATA_W, 4, tile type width.
- BOARD_BLOCKS, 768, number of valid blocks (32x24); valid addresses are 0..BOARD_BLOCKS-1.

Ports:
- CLOCK_50  input  1  system clock.
- reset  input  1  synchronous, active-high.
- req  input  N_REQ  per-requester command valid; level, held until ack.
- old_addr  input  N_REQ*ADDR_W  packed; slice i is requester i's block to restore.
- old_data  input  N_REQ*DATA_W  tile type written at old_addr, e.g. empty or pellet.
- new_addr  input  N_REQ*ADDR_W  block to draw the sprite on.
- new_data  input  N_REQ*DATA_W  sprite tile type.
- ack  output  N_REQ  one-cycle pulse to the granted requester on completion.
- busy  output  1  high in every state except IDLE.
- grant_id  output  $clog2(N_REQ)  index of the command currently being executed.
- wren  output  1  RAM write enable.
- write_addr  output  ADDR_W  RAM write address.
- write_data  output  DATA_W  RAM write data.
- err  output  1  one-cycle pulse when a latched address is >= BOARD_BLOCKS.

Behaviour:
- States are IDLE, CLEAR, DRAW and DONE. All outputs are registered.
- Reset values:
  - State is IDLE; ack, wren, err and busy are 0.
  - write_addr, write_data and grant_id are 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 wins first.
- IDLE:
  - If any req bit is set, pick the winner g, the first set bit searching from (last+1) mod N_REQ upward with wrap.
  - Latch g and its four command fields into internal registers, set grant_id=g, and go to CLEAR.
  - If no req bit is set, stay in IDLE.
- CLEAR (one cycle): wren=1, write_addr=latched old_addr, write_data=latched old_data.
- DRAW (one cycle): wren=1, write_addr=latched new_addr, write_data=latched new_data.
- DONE (one cycle): wren=0, ack[g]=1, last=g, then return to IDLE.
- Latency: req sampled at edge t gives CLEAR write at t+1, DRAW write at t+2, ack at t+3. The next grant is sampled at t+4.
- Throughput: at most one move per 4 cycles.
- Requester rules:
  - Hold req and the command fields stable until ack is seen, then deassert req on the next cycle.
  - A req still high in the IDLE cycle after ack is treated as a new command.
- req dropped after latch: the command completes and ack still pulses.
- The scheduler never reads inputs other than in IDLE.
- old_addr == new_addr: the CLEAR cycle is still spent but wren=0 in it; DRAW writes normally. Latency is unchanged.
- Address >= BOARD_BLOCKS:
  - wren=0 for that phase.
  - err pulses for one cycle in that phase.
  - The command still completes and is acked.
- Arithmetic: pointer increments mod N_REQ. No other arithmetic.
- Reset mid-operation: on the next edge the FSM returns to IDLE, wren=0 and no ack is issued. A second write already performed is not undone.
- Simultaneous requests: exactly one winner per grant. A requester that is continuously requesting waits at most N_REQ-1 grants.

Optional Feature:
- Macro: PAC_PRIORITY_EN.
- Defined:
  - Requester 0 (Pac-Man) wins whenever req[0] is set in IDLE, regardless of the pointer.
  - The other requesters are round-robin among themselves. last tracks only non-zero grants.
  - Ghosts may starve only while Pac-Man requests continuously.
- Undefined: pure round-robin as described above.

Test Plan:
- Single move: after reset, req[0]=1, old_addr0=495, old_data0=0, new_addr0=496, new_data0=3.
  - Expected: wren at t+1 with addr 495 data 0, wren at t+2 with addr 496 data 3, ack[0] pulse at t+3, busy high t+1..t+3.
- Round-robin: req=4'b1111 held, each requester deasserting one cycle after its ack.
  - Expected: grant order 0,1,2,3; four acks spaced 4 cycles apart; no overlapping wren pairs.
- Same address: old_addr1=new_addr1=300, new_data1=5.
  - Expected: CLEAR cycle wren=0, DRAW writes 300/5, ack[1] at t+3.
- Out of range: new_addr2=800.
  - Expected: CLEAR writes normally; DRAW has wren=0 and err=1; ack[2] still at t+3.
- Reset mid-op: assert reset in the DRAW cycle.
  - Expected: next cycle wren=0, busy=0, no ack; the following req=4'b0001 is granted to 0.
- PAC_PRIORITY_EN: req=4'b0011 held with req[0] reasserted after each ack.
  - Expected: requester 0 granted every time.
  - Expected without the macro: alternating 0,1.
